// File: rtl/prog_enc_pkg.sv
// prog_enc_pkg: shared definitions for the program encoder.
// Holds the run opcode numbering (matching the 9-bit instruction decoder),
// the request kind encoding, the instruction-type bit and the word typedef.
package prog_enc_pkg;

    typedef enum logic [3:0] {
        OP_LDI = 4'b0000,
        OP_LD  = 4'b0001,
        OP_ST  = 4'b0010,
        OP_ADD = 4'b0011,
        OP_SUB = 4'b0100,
        OP_XOR = 4'b0101,
        OP_OR  = 4'b0110,
        OP_AND = 4'b0111,
        OP_JMP = 4'b1000,
        OP_BEQ = 4'b1001,
        OP_BLT = 4'b1010,
        OP_BGT = 4'b1011,
        OP_SHL = 4'b1100,
        OP_SHR = 4'b1101
    } opcode_e;

    typedef enum logic [1:0] {
        KIND_RUN  = 2'd0,
        KIND_PUT  = 2'd1,
        KIND_PAIR = 2'd2,
        KIND_RSVD = 2'd3
    } kind_e;

    // Bit 0 of every instruction word tells the decoder which format follows.
    localparam logic ITYPE_RUN = 1'b0;
    localparam logic ITYPE_PUT = 1'b1;

    typedef logic [8:0] instr_word_t;

    // Opcodes above SHR have no meaning to the decoder.
    function automatic logic opcode_legal(input logic [3:0] op);
        return op <= OP_SHR;
    endfunction

endpackage

// File: rtl/prog_encoder_instr_pack.sv
// instr_pack: combinational packer turning (itype, opcode, value) into one
// 9-bit instruction word. RUN words carry the opcode in bits 4:1 with the
// upper nibble zero; PUT words carry the full 8-bit value in bits 8:1.
module instr_pack
    import prog_enc_pkg::*;
(
    input  logic        itype,
    input  logic [3:0]  opcode,
    input  logic [7:0]  value,
    output instr_word_t word
);

    // Select the word format from the instruction type bit.
    always_comb begin
        if (itype == ITYPE_PUT) begin
            word = {value, ITYPE_PUT};
        end else begin
            word = {4'b0000, opcode, ITYPE_RUN};
        end
    end

endmodule

// File: rtl/prog_encoder.sv
// prog_encoder: accepts operation requests over valid/ready, packs them into
// 9-bit instruction words and writes them sequentially into instruction
// memory. A PAIR request becomes a PUT word followed next cycle by a RUN word.
// Optional feature macro: PROG_ENCODER_OPCHECK_EN rejects run opcodes
// 1110/1111 (for RUN and PAIR) the same way as the reserved request kind.
module prog_encoder
    import prog_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [3:0]        req_opcode,
    input  logic [7:0]        req_value,
    output logic              instr_we,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [8:0]        instr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_op,
    output logic              err_ovf
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_PAIR2 = 1'b1;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] TWO      = (ADDR_W + 1)'(2);

    logic [0:0]      state;
    logic [3:0]      pend_opcode;
    logic            accept;
    logic            op_bad;
    logic            reject_op;
    logic            no_space;
    logic [ADDR_W:0] free_words;
    logic            pack_itype;
    logic [3:0]      pack_opcode;
    logic [7:0]      pack_value;
    instr_word_t     pack_word;

    assign full       = (count == CAPACITY);
    assign req_ready  = (state == ST_IDLE) && !full;
    assign accept     = req_valid && req_ready;
    assign free_words = CAPACITY - count;

`ifdef PROG_ENCODER_OPCHECK_EN
    assign op_bad = (req_kind != KIND_PUT) && !opcode_legal(req_opcode);
`else
    assign op_bad = 1'b0;
`endif

    assign reject_op = (req_kind == KIND_RSVD) || op_bad;

    // A PAIR must fit completely or not at all, so it needs two free slots.
    assign no_space = (req_kind == KIND_PAIR) ? (free_words < TWO)
                                              : (free_words == '0);

    // Choose what to pack: the latched RUN half while finishing a PAIR,
    // otherwise the incoming request (a PAIR starts with its PUT half).
    always_comb begin
        pack_itype  = ITYPE_PUT;
        pack_opcode = req_opcode;
        pack_value  = req_value;
        if (state == ST_PAIR2) begin
            pack_itype  = ITYPE_RUN;
            pack_opcode = pend_opcode;
        end else if (req_kind == KIND_RUN) begin
            pack_itype = ITYPE_RUN;
        end
    end

    instr_pack u_pack (
        .itype  (pack_itype),
        .opcode (pack_opcode),
        .value  (pack_value),
        .word   (pack_word)
    );

    // FSM, write port, word counter and sticky error flags; clear wins over
    // both a new request and the pending RUN half of a PAIR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pend_opcode <= 4'b0000;
            instr_we    <= 1'b0;
            instr_addr  <= '0;
            instr_data  <= '0;
            count       <= '0;
            err_op      <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            instr_we <= 1'b0;
            if (clear) begin
                state      <= ST_IDLE;
                instr_addr <= '0;
                count      <= '0;
                err_op     <= 1'b0;
                err_ovf    <= 1'b0;
            end else if (state == ST_PAIR2) begin
                instr_we   <= 1'b1;
                instr_addr <= count[ADDR_W-1:0];
                instr_data <= pack_word;
                count      <= count + ONE;
                state      <= ST_IDLE;
            end else if (accept) begin
                if (reject_op) begin
                    err_op <= 1'b1;
                end else if (no_space) begin
                    err_ovf <= 1'b1;
                end else begin
                    instr_we   <= 1'b1;
                    instr_addr <= count[ADDR_W-1:0];
                    instr_data <= pack_word;
                    count      <= count + ONE;
                    if (req_kind == KIND_PAIR) begin
                        state       <= ST_PAIR2;
                        pend_opcode <= req_opcode;
                    end
                end
            end
        end
    end

endmodule

// File: doc/prog_encoder.md
# prog_encoder

Instruction-word encoder and program loader: the write-side counterpart of the 9-bit instruction decoder. It accepts operation requests over a valid/ready handshake and packs them into 9-bit instruction words. It writes the words sequentially into instruction memory. Composite requests are expanded into a put word followed by a run word, so a full 8-bit operand and its consuming operation land in consecutive addresses.

## Interface
- ADDR_W, 8, instruction-memory address width; capacity is 2**ADDR_W words
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous rewind: address, count and flags to zero
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request this cycle
- req_kind  in  2  0=RUN, 1=PUT, 2=PAIR (PUT then RUN), 3=reserved
- req_opcode  in  4  run opcode (instr[4:1])
- req_value  in  8  put value (instr[8:1])
- instr_we  out  1  instruction-memory write strobe
- instr_addr  out  ADDR_W  write address
- instr_data  out  9  encoded word
- count  out  ADDR_W+1  words written since reset/clear
- full  out  1  count == 2**ADDR_W
- err_op  out  1  sticky: rejected opcode/kind
- err_ovf  out  1  sticky: request dropped for lack of space

## Operation
- Word format:
  - RUN word = {4'b0000, opcode, 1'b0}.
  - PUT word = {value, 1'b1}.
- Legal run opcodes are 0000–1101; 1110/1111 are illegal.
- States:
  - IDLE: req_ready = !full.
  - PAIR2: req_ready = 0. Emits the RUN half of a PAIR.
- A request is accepted on a rising edge with req_valid && req_ready.
  - RUN or PUT: one word written, stay IDLE.
  - PAIR: PUT word written, go to PAIR2. Next cycle the RUN word is written, return to IDLE.
- Opcode and kind are latched at acceptance, so the PAIR2 word is independent of later inputs.
- Space check is atomic:
  - A PAIR needs 2 free words; RUN and PUT need 1.
  - If space is insufficient, the request is accepted, nothing is written, and err_ovf is set.
  - A PAIR with exactly 1 free word therefore writes nothing.
- Kind 3 is accepted, not written, and sets err_op.
- Each write: instr_addr = count[ADDR_W-1:0], then count increments. Count saturates at 2**ADDR_W; there is no address wrap.
- clear has priority over acceptance and over PAIR2:
  - The pending RUN half is dropped.
  - FSM goes to IDLE; count, err_op and err_ovf go to 0.
- Reset values: state IDLE, req_ready 1, instr_we 0, instr_addr 0, instr_data 0, count 0, full 0, err_op 0, err_ovf 0.

## Timing
- instr_we, instr_addr and instr_data are registered. They are valid the cycle after acceptance (latency 1) and instr_we is a one-cycle pulse per word.
- A PAIR accepted at edge N writes at edges N+1 (PUT) and N+2 (RUN). The next request can be accepted at edge N+2.
- Back-to-back RUN/PUT requests sustain one word per cycle.
- full and count update together with the write strobe.
- A request that fills the last slot drops req_ready the following cycle.
- rst_n asserted mid-PAIR: all outputs return to reset values immediately and the RUN half is lost.

## Configuration
- PROG_ENCODER_OPCHECK_EN:
  - Defined: illegal run opcodes (RUN or PAIR) are rejected as for kind 3. The request is accepted, nothing is written, and err_op is set. For a PAIR the PUT half is also suppressed.
  - Undefined: any opcode is encoded verbatim and err_op is set only by kind 3.

## Structure
- Shared package prog_enc_pkg holds:
  - the opcode enum, matching the decoder numbering: LDI 0000, LD 0001, ST 0010, ADD 0011, SUB 0100, XOR 0101, OR 0110, AND 0111, JMP 1000, BEQ 1001, BLT 1010, BGT 1011, SHL 1100, SHR 1101
  - the kind enum
  - ITYPE_RUN/ITYPE_PUT bit constants
  - the 9-bit instruction word typedef
- One combinational sub-module, instr_pack, builds a word from (itype, opcode, value). FSM, counter and flags stay in prog_encoder.

## Test plan
- Reset, then RUN opcode 0011 → at addr 0, data 9'b0_0000_0110, count 1, instr_we one cycle.
- PAIR value 8'hA5, opcode 0000 at count 3 → addr 3 = 9'h14B, addr 4 = 9'h000, req_ready low one cycle, count 5.
- ADDR_W=2, three PUTs then a PAIR → nothing written, err_ovf 1, count 3, full 0. A further PUT writes addr 3 and full goes to 1.
- RUN opcode 1110 → with PROG_ENCODER_OPCHECK_EN: no write, err_op 1. Without it: 9'h01C written.
- clear asserted in PAIR2 → no RUN half written, count 0, flags cleared, req_ready 1 next cycle.
- rst_n low mid-stream asynchronously → all outputs at reset values before the next edge.
